complex_vxc_add_8_delay: RTL and testbench

Pipelined complex vector-times-scalar plus/minus vector unit. Each cycle it computes NI lanes of `first_row × constant ± second_row` on packed complex fixed-point elements. It sits under the vXc_mul3_add sequencer, which feeds row slices, watches `finish`, and writes `result` to result memory.

---
 rtl/complex_vxc_pkg.sv | 44 ++++
 rtl/complex_vxc_add_8_delay_if.sv | 22 ++
 rtl/complex_mac_lane.sv | 61 ++++++
 rtl/complex_vxc_add_8_delay.sv | 57 +++++
 tb/tb_complex_vxc_add_8_delay.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/complex_vxc_pkg.sv
// Shared types and arithmetic helpers for the complex vector-times-scalar
// plus/minus vector unit.
// Build option: COMPLEX_VXC_SAT_EN -- saturate instead of wrapping.
package complex_vxc_pkg;

  localparam int ELEM_W = 64;
  localparam int PART_W = 32;
  localparam int FRAC_W = 16;

  localparam logic [PART_W-1:0] POS_MAX = 32'h7FFF_FFFF;
  localparam logic [PART_W-1:0] NEG_MIN = 32'h8000_0000;

  // Complex element: real part in the upper half, imaginary in the lower.
  typedef struct packed {
    logic [PART_W-1:0] re;
    logic [PART_W-1:0] im;
  } cplx_t;

  // Bring a full Q32.32 product back to Q16.16.
  function automatic logic [PART_W-1:0] rescale(input logic [2*PART_W-1:0] p);
`ifdef COMPLEX_VXC_SAT_EN
    // Any disagreement in the bits above the kept field means overflow.
    if (p[2*PART_W-1:PART_W+FRAC_W-1] != {(PART_W-FRAC_W+1){p[2*PART_W-1]}})
      rescale = p[2*PART_W-1] ? NEG_MIN : POS_MAX;
    else
      rescale = p[PART_W+FRAC_W-1:FRAC_W];
`else
    rescale = p[PART_W+FRAC_W-1:FRAC_W];
`endif
  endfunction

  // Reduce a 33-bit sign-extended sum/difference to 32 bits.
  function automatic logic [PART_W-1:0] fit32(input logic [PART_W:0] s);
`ifdef COMPLEX_VXC_SAT_EN
    if (s[PART_W] != s[PART_W-1])
      fit32 = s[PART_W] ? NEG_MIN : POS_MAX;
    else
      fit32 = s[PART_W-1:0];
`else
    fit32 = s[PART_W-1:0];
`endif
  endfunction

endpackage

// File: rtl/complex_vxc_add_8_delay_if.sv
// Data bus between the row sequencer and the complex vector unit.
interface complex_vxc_add_8_delay_if #(
  parameter int NI = 8,
  parameter int EW = 64
);
  logic [NI*EW-1:0] first_row_input;
  logic [EW-1:0]    constant;
  logic [NI*EW-1:0] second_row_input;
  logic             op;
  logic [NI*EW-1:0] result;
  logic             finish;

  modport master (
    output first_row_input, constant, second_row_input, op,
    input  result, finish
  );

  modport slave (
    input  first_row_input, constant, second_row_input, op,
    output result, finish
  );
endinterface

// File: rtl/complex_mac_lane.sv
// One lane of the 3-stage datapath: R = A*C +/- B on Q16.16 complex parts.
// C and op are registered once in the top level and shared by every lane.
module complex_mac_lane
  import complex_vxc_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  cplx_t i_a,
  input  cplx_t i_b,
  input  cplx_t i_c_s1,
  input  logic  i_op_s2,
  output cplx_t o_r
);

  cplx_t r_a_s1, r_b_s1, r_b_s2, r_r_s3;
  logic [PART_W-1:0] r_rr, r_ii, r_ri, r_ir;

  logic signed [2*PART_W-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;
  logic [PART_W-1:0] w_p_re, w_p_im;
  cplx_t w_r;

  // Full-width signed partial products from the stage-1 operands.
  assign w_p_rr = $signed(r_a_s1.re) * $signed(i_c_s1.re);
  assign w_p_ii = $signed(r_a_s1.im) * $signed(i_c_s1.im);
  assign w_p_ri = $signed(r_a_s1.re) * $signed(i_c_s1.im);
  assign w_p_ir = $signed(r_a_s1.im) * $signed(i_c_s1.re);

  // Combine the rescaled products, then add or subtract B.
  assign w_p_re = fit32({r_rr[PART_W-1], r_rr} - {r_ii[PART_W-1], r_ii});
  assign w_p_im = fit32({r_ri[PART_W-1], r_ri} + {r_ir[PART_W-1], r_ir});
  assign w_r.re = i_op_s2 ? fit32({w_p_re[PART_W-1], w_p_re} - {r_b_s2.re[PART_W-1], r_b_s2.re})
                          : fit32({w_p_re[PART_W-1], w_p_re} + {r_b_s2.re[PART_W-1], r_b_s2.re});
  assign w_r.im = i_op_s2 ? fit32({w_p_im[PART_W-1], w_p_im} - {r_b_s2.im[PART_W-1], r_b_s2.im})
                          : fit32({w_p_im[PART_W-1], w_p_im} + {r_b_s2.im[PART_W-1], r_b_s2.im});

  // Pipeline registers: operands, rescaled partial products, result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a_s1 <= '0;
      r_b_s1 <= '0;
      r_b_s2 <= '0;
      r_rr   <= '0;
      r_ii   <= '0;
      r_ri   <= '0;
      r_ir   <= '0;
      r_r_s3 <= '0;
    end else begin
      r_a_s1 <= i_a;
      r_b_s1 <= i_b;
      r_b_s2 <= r_b_s1;
      r_rr   <= rescale(w_p_rr);
      r_ii   <= rescale(w_p_ii);
      r_ri   <= rescale(w_p_ri);
      r_ir   <= rescale(w_p_ir);
      r_r_s3 <= w_r;
    end
  end

  assign o_r = r_r_s3;

endmodule

// File: rtl/complex_vxc_add_8_delay.sv
// Pipelined complex vector-times-scalar plus/minus vector, NI lanes,
// 3-cycle latency, one vector per cycle.
// Build option: COMPLEX_VXC_SAT_EN -- saturate instead of wrapping.
module complex_vxc_add_8_delay
  import complex_vxc_pkg::*;
#(
  parameter int NI = 8,
  parameter int EW = ELEM_W
) (
  input logic clk,
  input logic reset,
  complex_vxc_add_8_delay_if.slave bus
);

  cplx_t            r_c;
  logic             r_op_s1, r_op_s2;
  logic [1:0]       r_cnt;
  logic             r_finish;
  logic [NI*EW-1:0] w_result;

  // Shared scalar/op pipeline and the finish count after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_c      <= '0;
      r_op_s1  <= 1'b0;
      r_op_s2  <= 1'b0;
      r_cnt    <= '0;
      r_finish <= 1'b0;
    end else begin
      r_c     <= bus.constant;
      r_op_s1 <= bus.op;
      r_op_s2 <= r_op_s1;
      if (!r_finish) begin
        r_cnt    <= r_cnt + 2'd1;
        r_finish <= (r_cnt == 2'd2);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_lane
      complex_mac_lane u_lane (
        .clk    (clk),
        .reset  (reset),
        .i_a    (bus.first_row_input[gi*EW +: EW]),
        .i_b    (bus.second_row_input[gi*EW +: EW]),
        .i_c_s1 (r_c),
        .i_op_s2(r_op_s2),
        .o_r    (w_result[gi*EW +: EW])
      );
    end
  endgenerate

  assign bus.result = w_result;
  assign bus.finish = r_finish;

endmodule

// File: tb/tb_complex_vxc_add_8_delay.sv
// Directed bench for complex_vxc_add_8_delay (8 lanes, 64-bit elements).
module tb_complex_vxc_add_8_delay;

  localparam int NI = 8;
  localparam int EW = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  complex_vxc_add_8_delay_if #(.NI(NI), .EW(EW)) bus ();

  complex_vxc_add_8_delay #(.NI(NI), .EW(EW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Integer parts to a Q16.16 complex element.
  function automatic logic [63:0] mk(input int re, input int im);
    logic [31:0] r, i;
    r = re * 65536;
    i = im * 65536;
    return {r, i};
  endfunction

  function automatic logic [NI*EW-1:0] rep(input logic [63:0] e);
    logic [NI*EW-1:0] v;
    for (int k = 0; k < NI; k++) v[k*EW +: EW] = e;
    return v;
  endfunction

  task automatic apply(input logic [NI*EW-1:0] a, input logic [63:0] c,
                       input logic [NI*EW-1:0] b, input logic o);
    @(negedge clk);
    bus.first_row_input  = a;
    bus.constant         = c;
    bus.second_row_input = b;
    bus.op               = o;
  endtask

  task automatic test_reset;
    bus.first_row_input  = '0;
    bus.constant         = '0;
    bus.second_row_input = '0;
    bus.op               = 1'b0;
    reset = 1'b0;
    #1;
    n_vec++;
    if (bus.result !== '0) begin
      n_err++; $display("FAIL reset_result: got %h expected 0", bus.result);
    end
    n_vec++;
    if (bus.finish !== 1'b0) begin
      n_err++; $display("FAIL reset_finish: got %b expected 0", bus.finish);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      n_vec++;
      if (bus.finish !== (e >= 3)) begin
        n_err++; $display("FAIL finish_edge%0d: got %b expected %b", e, bus.finish, (e >= 3));
      end
    end
  endtask

  task automatic test_add;
    logic [NI*EW-1:0] exp_v;
    exp_v = rep({32'hFFFC_0000, 32'h000B_0000});
    apply(rep(mk(1, 2)), mk(3, 4), rep(mk(1, 1)), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (bus.result !== exp_v) begin
      n_err++; $display("FAIL add: got %h expected %h", bus.result, exp_v);
    end
    $display("add: result lane0 %h", bus.result[63:0]);
  endtask

  task automatic test_sub;
    logic [NI*EW-1:0] exp_v;
    exp_v = rep({32'hFFFA_0000, 32'h0009_0000});
    apply(rep(mk(1, 2)), mk(3, 4), rep(mk(1, 1)), 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (bus.result !== exp_v) begin
      n_err++; $display("FAIL sub: got %h expected %h", bus.result, exp_v);
    end
    $display("sub: result lane0 %h", bus.result[63:0]);
  endtask

  task automatic test_back_to_back;
    logic [NI*EW-1:0] a_v[8], b_v[8], exp_v[8];
    logic [63:0]      c_v[8];
    logic             op_v[8];
    for (int c = 0; c < 8; c++) begin
      int cre, cim;
      cre = c + 1; cim = 1 - c;
      c_v[c]  = mk(cre, cim);
      op_v[c] = c[0];
      for (int k = 0; k < NI; k++) begin
        int are, aim, bre, bim, rre, rim;
        are = c + k + 1; aim = k - c; bre = 10 * k + 3; bim = c - 2 * k;
        rre = are * cre - aim * cim;
        rim = are * cim + aim * cre;
        if (op_v[c]) begin rre = rre - bre; rim = rim - bim; end
        else         begin rre = rre + bre; rim = rim + bim; end
        a_v[c][k*EW +: EW]   = mk(are, aim);
        b_v[c][k*EW +: EW]   = mk(bre, bim);
        exp_v[c][k*EW +: EW] = mk(rre, rim);
      end
    end
    for (int c = 0; c < 10; c++) begin
      if (c < 8) apply(a_v[c], c_v[c], b_v[c], op_v[c]);
      else @(negedge clk);
      @(posedge clk); #1;
      if (c >= 2) begin
        n_vec++;
        if (bus.result !== exp_v[c-2]) begin
          n_err++; $display("FAIL stream%0d: got %h expected %h", c - 2, bus.result, exp_v[c-2]);
        end
        $display("stream vector %0d: lane0 %h lane7 %h", c - 2, bus.result[63:0], bus.result[511:448]);
      end
    end
  endtask

  task automatic test_mid_reset;
    apply(rep(mk(5, -3)), mk(2, 7), rep(mk(1, 1)), 1'b0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_vec++;
    if (bus.result !== '0) begin
      n_err++; $display("FAIL midreset_result: got %h expected 0", bus.result);
    end
    n_vec++;
    if (bus.finish !== 1'b0) begin
      n_err++; $display("FAIL midreset_finish: got %b expected 0", bus.finish);
    end
    apply('0, '0, '0, 1'b0);
    reset = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      n_vec++;
      if (e < 3 && bus.result !== '0) begin
        n_err++; $display("FAIL discard_edge%0d: got %h expected 0", e, bus.result);
      end
      if (e == 3 && bus.finish !== 1'b1) begin
        n_err++; $display("FAIL refinish: got %b expected 1", bus.finish);
      end
    end
  endtask

  task automatic test_overflow;
    logic [NI*EW-1:0] exp_v;
`ifdef COMPLEX_VXC_SAT_EN
    exp_v = rep({32'h7FFF_FFFF, 32'h0000_0000});
`else
    exp_v = rep({32'hFFFE_0000, 32'h0000_0000});
`endif
    apply(rep(mk(32767, 0)), mk(2, 0), '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (bus.result !== exp_v) begin
      n_err++; $display("FAIL overflow: got %h expected %h", bus.result, exp_v);
    end
    $display("overflow: lane0 %h", bus.result[63:0]);
  endtask

  task automatic test_fraction;
    logic [NI*EW-1:0] exp_v;
    exp_v = rep({32'h0000_4000, 32'h0000_0000});
    apply(rep({32'h0000_8000, 32'h0}), {32'h0000_8000, 32'h0}, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (bus.result !== exp_v) begin
      n_err++; $display("FAIL fraction: got %h expected %h", bus.result, exp_v);
    end
    $display("fraction: lane0 %h", bus.result[63:0]);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_mid_reset();
    test_overflow();
    test_fraction();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
